// File: rtl/sfp_row_seq.sv
// sfp_row_seq: sequences one sfp_row normalisation datapath over a tile of
// num_rows psum rows. It accumulates the per-row sums, optionally exchanges
// sums with a peer core, then replays the rows through the divider.
module sfp_row_seq #(
  parameter int num_rows = 8,
  parameter int cnt_bw   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              single_core,
  input  logic              in_valid,
  output logic              in_rd,
  output logic              acc,
  output logic              div,
  output logic              fifo_ext_rd,
  output logic              sum_ready,
  input  logic              peer_sum_ready,
  output logic              out_valid,
  output logic [cnt_bw-1:0] row_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    SYNC,
    XCHG,
    DIV,
    DRAIN,
    DONE
  } state_t;

  localparam logic [cnt_bw-1:0] last_row = cnt_bw'(num_rows - 1);

  state_t            state, next_state;
  logic [cnt_bw-1:0] cnt, cnt_next;
  logic              single_q, single_next;
  logic              at_last;

  assign at_last = (cnt == last_row);

  // Next-state decode plus the pulse outputs that follow state and in_valid.
  always_comb begin
    next_state  = state;
    cnt_next    = cnt;
    single_next = single_q;
    acc         = 1'b0;
    div         = 1'b0;
    fifo_ext_rd = 1'b0;
    in_rd       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_next    = '0;
          single_next = single_core;
          next_state  = ACC;
        end
      end
      ACC: begin
        acc   = in_valid;
        in_rd = in_valid;
        if (in_valid) begin
          if (at_last) begin
            cnt_next   = '0;
            next_state = single_q ? DIV : SYNC;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      SYNC: begin
        if (peer_sum_ready) begin
          next_state = XCHG;
        end
      end
      XCHG: begin
        fifo_ext_rd = 1'b1;
        if (at_last) begin
          cnt_next   = '0;
          next_state = DIV;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DIV: begin
        div   = in_valid;
        in_rd = in_valid;
        if (in_valid) begin
          if (at_last) begin
            cnt_next   = '0;
            next_state = DRAIN;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; out_valid trails each divide by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      single_q  <= 1'b0;
      sum_ready <= 1'b0;
      out_valid <= 1'b0;
      row_idx   <= '0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      single_q  <= single_next;
      sum_ready <= (next_state == SYNC);
      out_valid <= div;
      if (div) begin
        row_idx <= cnt;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sfp_row_seq.sv
// Directed testbench for sfp_row_seq: a num_rows=8 instance for the main
// scenarios and a num_rows=1 instance for the single-row boundary.
module tb_sfp_row_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       single_core = 1'b0;
  logic       in_valid = 1'b0;
  logic       peer_sum_ready = 1'b0;

  logic       in_rd, acc, div, fifo_ext_rd, sum_ready, out_valid, busy, done;
  logic [3:0] row_idx;
  logic       in_rd_b, acc_b, div_b, fifo_ext_rd_b, sum_ready_b, out_valid_b, busy_b, done_b;
  logic [3:0] row_idx_b;

  int checks = 0;
  int failures = 0;

  int cyc;
  bit sel2;
  int acc_n, div_n, xr_n, ov_n, sr_n, done_n, err_n, row_err, busy_after;
  int acc_first, acc_last, div_first, div_last, xr_first, xr_last;
  int ov_first, ov_last, sr_first, done_cyc, busy_low, exp_row;

  sfp_row_seq #(.num_rows(8), .cnt_bw(4)) dut (
    .clk(clk), .reset(reset), .start(start), .single_core(single_core),
    .in_valid(in_valid), .in_rd(in_rd), .acc(acc), .div(div),
    .fifo_ext_rd(fifo_ext_rd), .sum_ready(sum_ready),
    .peer_sum_ready(peer_sum_ready), .out_valid(out_valid),
    .row_idx(row_idx), .busy(busy), .done(done)
  );

  sfp_row_seq #(.num_rows(1), .cnt_bw(4)) dut_one (
    .clk(clk), .reset(reset), .start(start2), .single_core(single_core),
    .in_valid(in_valid), .in_rd(in_rd_b), .acc(acc_b), .div(div_b),
    .fifo_ext_rd(fifo_ext_rd_b), .sum_ready(sum_ready_b),
    .peer_sum_ready(peer_sum_ready), .out_valid(out_valid_b),
    .row_idx(row_idx_b), .busy(busy_b), .done(done_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearMon(input bit use_second);
    sel2 = use_second;
    cyc = -1;
    acc_n = 0; div_n = 0; xr_n = 0; ov_n = 0; sr_n = 0; done_n = 0;
    err_n = 0; row_err = 0; busy_after = 0; exp_row = 0;
    acc_first = -1; acc_last = -1; div_first = -1; div_last = -1;
    xr_first = -1; xr_last = -1; ov_first = -1; ov_last = -1;
    sr_first = -1; done_cyc = -1; busy_low = -1;
  endtask

  function automatic int outVec(input bit second);
    if (second)
      return int'({in_rd_b, acc_b, div_b, fifo_ext_rd_b, sum_ready_b,
                   out_valid_b, row_idx_b, busy_b, done_b});
    return int'({in_rd, acc, div, fifo_ext_rd, sum_ready,
                 out_valid, row_idx, busy, done});
  endfunction

  // Drives one cycle of inputs just after the edge, then samples on the falling edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic st2,
                               input logic sc, input logic iv, input logic pr);
    logic o_rd, o_acc, o_div, o_xr, o_sr, o_ov, o_busy, o_done;
    logic [3:0] o_row;
    @(posedge clk);
    #1;
    reset = rst; start = st; start2 = st2; single_core = sc;
    in_valid = iv; peer_sum_ready = pr;
    @(negedge clk);
    cyc++;
    if (sel2) begin
      o_rd = in_rd_b; o_acc = acc_b; o_div = div_b; o_xr = fifo_ext_rd_b;
      o_sr = sum_ready_b; o_ov = out_valid_b; o_row = row_idx_b;
      o_busy = busy_b; o_done = done_b;
    end else begin
      o_rd = in_rd; o_acc = acc; o_div = div; o_xr = fifo_ext_rd;
      o_sr = sum_ready; o_ov = out_valid; o_row = row_idx;
      o_busy = busy; o_done = done;
    end
    if (o_acc) begin acc_n++; if (acc_first < 0) acc_first = cyc; acc_last = cyc; end
    if (o_div) begin div_n++; if (div_first < 0) div_first = cyc; div_last = cyc; end
    if (o_xr) begin xr_n++; if (xr_first < 0) xr_first = cyc; xr_last = cyc; end
    if (o_sr) begin sr_n++; if (sr_first < 0) sr_first = cyc; end
    if (o_ov) begin
      ov_n++;
      if (ov_first < 0) ov_first = cyc;
      ov_last = cyc;
      if (int'(o_row) != exp_row) row_err++;
      exp_row++;
    end
    if (o_done) begin done_n++; done_cyc = cyc; end
    if (!o_busy && cyc > 0 && busy_low < 0) busy_low = cyc;
    if (done_cyc >= 0 && cyc > done_cyc && o_busy) busy_after++;
    if ((int'(o_acc) + int'(o_div) + int'(o_xr)) > 1) err_n++;
    if (o_rd != (o_acc || o_div)) err_n++;
    if ((o_acc || o_div) && !iv) err_n++;
  endtask

  initial begin
    $display("[TB] sfp_row_seq directed test start");
    clearMon(1'b0);

    // Reset state, with in_valid high to show IDLE ignores it.
    applyStimulus(1, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("reset_outputs", outVec(1'b0), 0);
    checkOutput("reset_outputs_n1", outVec(1'b1), 0);

    // Single core, continuous in_valid.
    clearMon(1'b0);
    for (int c = 0; c < 25; c++) applyStimulus(0, c == 0, 0, 1, 1, 1);
    checkOutput("sc_acc_first", acc_first, 1);
    checkOutput("sc_acc_last", acc_last, 8);
    checkOutput("sc_acc_count", acc_n, 8);
    checkOutput("sc_div_first", div_first, 9);
    checkOutput("sc_div_last", div_last, 16);
    checkOutput("sc_ov_first", ov_first, 10);
    checkOutput("sc_ov_last", ov_last, 17);
    checkOutput("sc_ov_count", ov_n, 8);
    checkOutput("sc_row_seq", row_err, 0);
    checkOutput("sc_done_cycle", done_cyc, 18);
    checkOutput("sc_done_count", done_n, 1);
    checkOutput("sc_busy_low", busy_low, 19);
    checkOutput("sc_no_xchg", xr_n + sr_n, 0);
    checkOutput("sc_excl", err_n, 0);

    // Multi core, peer already ready.
    clearMon(1'b0);
    for (int c = 0; c < 32; c++) applyStimulus(0, c == 0, 0, 0, 1, 1);
    checkOutput("mc_sync_cycles", sr_n, 1);
    checkOutput("mc_sync_at", sr_first, 9);
    checkOutput("mc_xr_first", xr_first, 10);
    checkOutput("mc_xr_last", xr_last, 17);
    checkOutput("mc_xr_count", xr_n, 8);
    checkOutput("mc_div_first", div_first, 18);
    checkOutput("mc_div_count", div_n, 8);
    checkOutput("mc_done_cycle", done_cyc, 27);
    checkOutput("mc_row_seq", row_err, 0);
    checkOutput("mc_excl", err_n, 0);

    // Multi core, peer late by 20 cycles after SYNC entry at cycle 9.
    clearMon(1'b0);
    for (int c = 0; c < 52; c++) applyStimulus(0, c == 0, 0, 0, 1, c >= 29);
    checkOutput("wait_sync_cycles", sr_n, 21);
    checkOutput("wait_xr_first", xr_first, 30);
    checkOutput("wait_xr_count", xr_n, 8);
    checkOutput("wait_done_cycle", done_cyc, 47);
    checkOutput("wait_excl", err_n, 0);

    // in_valid pattern 1,0,0 repeating from cycle 1.
    clearMon(1'b0);
    for (int c = 0; c < 60; c++)
      applyStimulus(0, c == 0, 0, 1, (c >= 1) && ((c - 1) % 3 == 0), 1);
    checkOutput("gap_acc_count", acc_n, 8);
    checkOutput("gap_acc_last", acc_last, 22);
    checkOutput("gap_div_count", div_n, 8);
    checkOutput("gap_div_last", div_last, 46);
    checkOutput("gap_ov_count", ov_n, 8);
    checkOutput("gap_row_seq", row_err, 0);
    checkOutput("gap_done_cycle", done_cyc, 48);
    checkOutput("gap_excl", err_n, 0);

    // Reset during XCHG after three external reads.
    clearMon(1'b0);
    for (int c = 0; c < 14; c++) applyStimulus(c == 12, c == 0, 0, 0, 1, 1);
    checkOutput("abort_xr_count", xr_n, 3);
    checkOutput("abort_outputs", outVec(1'b0), 0);
    clearMon(1'b0);
    for (int c = 0; c < 22; c++) applyStimulus(0, c == 0, 0, 1, 1, 1);
    checkOutput("restart_acc_count", acc_n, 8);
    checkOutput("restart_ov_count", ov_n, 8);
    checkOutput("restart_done_cycle", done_cyc, 18);

    // start pulses while busy in ACC (cycle 4) and DIV (cycle 12).
    clearMon(1'b0);
    for (int c = 0; c < 26; c++)
      applyStimulus(0, (c == 0) || (c == 4) || (c == 12), 0, 1, 1, 1);
    checkOutput("busy_start_acc", acc_n, 8);
    checkOutput("busy_start_div", div_n, 8);
    checkOutput("busy_start_done", done_cyc, 18);
    checkOutput("busy_start_no_restart", busy_after, 0);

    // num_rows=1, multi core.
    clearMon(1'b1);
    for (int c = 0; c < 12; c++) applyStimulus(0, 0, c == 0, 0, 1, 1);
    checkOutput("n1_acc_count", acc_n, 1);
    checkOutput("n1_xr_count", xr_n, 1);
    checkOutput("n1_div_count", div_n, 1);
    checkOutput("n1_ov_count", ov_n, 1);
    checkOutput("n1_row_idx", row_err, 0);
    checkOutput("n1_done_cycle", done_cyc, 6);
    checkOutput("n1_excl", err_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
